// File: rtl/ped_signal_if.sv
// Signal bundle between the vehicle lamp source / pedestrian button and the
// pedestrian signal controller.
interface ped_signal_if;
  logic       red;
  logic       yellow;
  logic       green;
  logic       ped_btn;
  logic       walk;
  logic       dont_walk;
  logic       req_pending;
  logic [3:0] clear_cnt;
  logic       fault;

  // Lamp/button source side
  modport master (
    output red, yellow, green, ped_btn,
    input  walk, dont_walk, req_pending, clear_cnt, fault
  );

  // Pedestrian controller side
  modport slave (
    input  red, yellow, green, ped_btn,
    output walk, dont_walk, req_pending, clear_cnt, fault
  );
endinterface

// File: rtl/ped_signal.sv
// Pedestrian crossing controller: grants WALK at the onset of a vehicle red
// phase when a debounced request is pending, follows it with a flashing
// clearance interval, and latches a sticky fault on illegal lamp states.
module ped_signal #(
  parameter int WALK_CYCLES  = 8,
  parameter int CLEAR_CYCLES = 6,
  parameter int DEBOUNCE     = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  ped_signal_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, WAIT_RED, WALK, CLEAR, FAULT} state_t;

  localparam int DB_W = $clog2(DEBOUNCE + 1);
  localparam int WC_W = $clog2(WALK_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_MAX   = DB_W'(DEBOUNCE);
  localparam logic [DB_W-1:0] DB_ARM   = DB_W'(DEBOUNCE - 1);
  localparam logic [WC_W-1:0] WC_LAST  = WC_W'(WALK_CYCLES - 1);
  localparam logic [3:0]      CLR_LOAD = 4'(CLEAR_CYCLES);

  // Saturating increment so a long press produces a single request
  function automatic logic [DB_W-1:0] db_sat_inc(input logic [DB_W-1:0] v);
    return (v == DB_MAX) ? v : v + DB_W'(1);
  endfunction

  state_t          state_q, state_d;
  logic            red_q, ovl_q;
  logic            onset_p1, fault_p1;
  logic [DB_W-1:0] db_cnt, db_d;
  logic            req_q, req_d;
  logic [WC_W-1:0] wcnt_q, wcnt_d;
  logic            walk_q, walk_d;
  logic            dw_q, dw_d;
  logic [3:0]      cc_q, cc_d;
  logic            fault_q, fault_d;

  logic overlap, green_bad, req_set, req_next, go_walk;

  assign overlap   = (bus.red & bus.yellow) | (bus.red & bus.green) |
                     (bus.yellow & bus.green);
  assign green_bad = bus.green && (state_q == WALK || state_q == CLEAR);
  assign req_set   = bus.ped_btn && (db_cnt == DB_ARM) && (state_q != WALK);
  assign req_next  = req_q | req_set;

  // Next-state and next-output logic; fault detection overrides everything
  always_comb begin
    state_d = state_q;
    walk_d  = walk_q;
    dw_d    = dw_q;
    cc_d    = cc_q;
    wcnt_d  = wcnt_q;
    fault_d = fault_q;
    go_walk = 1'b0;
    db_d    = (state_q == WALK || !bus.ped_btn) ? '0 : db_sat_inc(db_cnt);

    case (state_q)
      IDLE: begin
        walk_d = 1'b0;
        dw_d   = 1'b1;
        cc_d   = 4'd0;
        if (req_next) begin
          if (onset_p1) go_walk = 1'b1;
          else          state_d = WAIT_RED;
        end
      end
      WAIT_RED: begin
        if (onset_p1) go_walk = 1'b1;
      end
      WALK: begin
        if (!bus.red || wcnt_q == WC_LAST) begin
          state_d = CLEAR;
          walk_d  = 1'b0;
          dw_d    = 1'b1;
          cc_d    = CLR_LOAD;
        end else begin
          wcnt_d = wcnt_q + WC_W'(1);
        end
      end
      CLEAR: begin
        if (cc_q == 4'd1) begin
          cc_d    = 4'd0;
          dw_d    = 1'b1;
          state_d = req_next ? WAIT_RED : IDLE;
        end else begin
          cc_d = cc_q - 4'd1;
          dw_d = ~dw_q;
        end
      end
      FAULT: begin
        walk_d  = 1'b0;
        dw_d    = 1'b1;
        cc_d    = 4'd0;
        fault_d = 1'b1;
      end
      default: state_d = FAULT;
    endcase

    if (go_walk) begin
      state_d = WALK;
      walk_d  = 1'b1;
      dw_d    = 1'b0;
      wcnt_d  = '0;
    end

    if (fault_p1) begin
      state_d = FAULT;
      walk_d  = 1'b0;
      dw_d    = 1'b1;
      cc_d    = 4'd0;
      fault_d = 1'b1;
    end

    req_d = (state_d == WALK && state_q != WALK) ? 1'b0 : req_next;
  end

  // Registered state, outputs and lamp-event pipeline (onset / fault flags)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      red_q    <= 1'b0;
      ovl_q    <= 1'b0;
      onset_p1 <= 1'b0;
      fault_p1 <= 1'b0;
      db_cnt   <= '0;
      req_q    <= 1'b0;
      wcnt_q   <= '0;
      walk_q   <= 1'b0;
      dw_q     <= 1'b1;
      cc_q     <= 4'd0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      red_q    <= bus.red;
      ovl_q    <= overlap;
      onset_p1 <= bus.red & ~red_q;
      fault_p1 <= (overlap & ovl_q) | green_bad;
      db_cnt   <= db_d;
      req_q    <= req_d;
      wcnt_q   <= wcnt_d;
      walk_q   <= walk_d;
      dw_q     <= dw_d;
      cc_q     <= cc_d;
      fault_q  <= fault_d;
    end
  end

  assign bus.walk        = walk_q;
  assign bus.dont_walk   = dw_q;
  assign bus.req_pending = req_q;
  assign bus.clear_cnt   = cc_q;
  assign bus.fault       = fault_q;

endmodule

// File: tb/tb_ped_signal.sv
// Directed bench for ped_signal with hand-computed expectations.
module tb_ped_signal;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  ped_signal_if bus();

  ped_signal #(.WALK_CYCLES(8), .CLEAR_CYCLES(6), .DEBOUNCE(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lamps(input logic r, input logic y, input logic g);
    bus.red = r; bus.yellow = y; bus.green = g;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.ped_btn = 1'b0;
    lamps(0, 0, 0);
    tick(); tick();
    chk("rst_walk", bus.walk, 0);
    chk("rst_dw", bus.dont_walk, 1);
    chk("rst_fault", bus.fault, 0);
    chk("rst_cc", bus.clear_cnt, 0);
    chk("rst_req", bus.req_pending, 0);

    // Full crossing: press during green, then green->yellow->red
    rst_n = 1'b1;
    lamps(0, 0, 1);
    tick(); tick();
    bus.ped_btn = 1'b1;
    tick();
    chk("fc_req_early", bus.req_pending, 0);
    tick();
    chk("fc_req_set", bus.req_pending, 1);
    bus.ped_btn = 1'b0;
    lamps(0, 1, 0);
    tick(); tick();
    chk("fc_walk_yellow", bus.walk, 0);
    lamps(1, 0, 0);
    tick();
    chk("fc_walk_onset_edge", bus.walk, 0);
    tick();
    chk("fc_walk_first", bus.walk, 1);
    chk("fc_dw_walk", bus.dont_walk, 0);
    chk("fc_req_cleared", bus.req_pending, 0);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("fc_walk_%0d", i), bus.walk, 1);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("fc_clr_walk_%0d", i), bus.walk, 0);
      chk($sformatf("fc_clr_dw_%0d", i), bus.dont_walk, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("fc_clr_cc_%0d", i), bus.clear_cnt, 6 - i);
    end
    tick();
    chk("fc_idle_cc", bus.clear_cnt, 0);
    chk("fc_idle_dw", bus.dont_walk, 1);
    chk("fc_idle_req", bus.req_pending, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("fc_red_tail_%0d", i), bus.walk, 0);
    end
    lamps(0, 0, 1);
    tick(); tick();

    // Press during an ongoing red: served only at the next red onset
    lamps(1, 0, 0);
    tick(); tick(); tick();
    bus.ped_btn = 1'b1;
    tick(); tick(); tick();
    bus.ped_btn = 1'b0;
    chk("pr_req", bus.req_pending, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("pr_no_walk_%0d", i), bus.walk, 0);
    end
    lamps(0, 0, 1);
    tick(); tick(); tick();
    chk("pr_green_walk", bus.walk, 0);
    lamps(0, 1, 0);
    tick(); tick();
    lamps(1, 0, 0);
    tick();
    chk("pr_onset_edge", bus.walk, 0);
    tick();
    chk("pr_walk", bus.walk, 1);
    chk("pr_req_clr", bus.req_pending, 0);

    // Early red end after 3 WALK cycles
    tick(); tick();
    chk("er_walk3", bus.walk, 1);
    lamps(0, 0, 0);
    tick();
    chk("er_walk_off", bus.walk, 0);
    chk("er_cc", bus.clear_cnt, 6);
    chk("er_dw", bus.dont_walk, 1);
    for (int i = 0; i < 5; i++) tick();
    chk("er_cc_last", bus.clear_cnt, 1);
    chk("er_dw_last", bus.dont_walk, 0);
    tick();
    chk("er_cc_done", bus.clear_cnt, 0);
    chk("er_dw_done", bus.dont_walk, 1);

    // Debounce reject: one-cycle pulse
    lamps(0, 0, 1);
    tick();
    bus.ped_btn = 1'b1;
    tick();
    bus.ped_btn = 1'b0;
    tick(); tick();
    chk("db_req", bus.req_pending, 0);
    lamps(0, 1, 0);
    tick();
    lamps(1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("db_no_walk_%0d", i), bus.walk, 0);
    end

    // Single-cycle lamp overlap is tolerated
    lamps(1, 0, 1);
    tick();
    lamps(1, 0, 0);
    tick(); tick(); tick();
    chk("ov1_fault", bus.fault, 0);
    lamps(0, 0, 1);
    tick(); tick();

    // Green while in WALK
    bus.ped_btn = 1'b1;
    tick(); tick();
    bus.ped_btn = 1'b0;
    lamps(0, 1, 0);
    tick();
    lamps(1, 0, 0);
    tick();
    tick();
    chk("gw_walk", bus.walk, 1);
    lamps(1, 0, 1);
    tick();
    chk("gw_fault_pre", bus.fault, 0);
    lamps(1, 0, 0);
    tick();
    chk("gw_fault", bus.fault, 1);
    chk("gw_walk_off", bus.walk, 0);
    chk("gw_dw", bus.dont_walk, 1);
    rst_n = 1'b0;
    tick();
    chk("gw_rst_fault", bus.fault, 0);
    rst_n = 1'b1;

    // Two-cycle red+green overlap
    lamps(1, 0, 1);
    tick();
    chk("ov2_e1", bus.fault, 0);
    tick();
    chk("ov2_e2", bus.fault, 0);
    tick();
    chk("ov2_fault", bus.fault, 1);
    chk("ov2_dw", bus.dont_walk, 1);
    lamps(1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("ov2_sticky_%0d", i), bus.fault, 1);
      chk($sformatf("ov2_dw_steady_%0d", i), bus.dont_walk, 1);
      chk($sformatf("ov2_cc_%0d", i), bus.clear_cnt, 0);
    end
    rst_n = 1'b0;
    tick();
    chk("ov2_rst_fault", bus.fault, 0);
    chk("ov2_rst_walk", bus.walk, 0);
    chk("ov2_rst_dw", bus.dont_walk, 1);
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
